// File: rtl/risc_seq_ctrl.sv
// risc_seq_ctrl: instruction queue feeding a three-state sequencer.
// An incoming word waits in a FIFO. The sequencer takes it from the FIFO head
// and issues load strobes in DECODE, then an execute strobe in EXEC.
// Optional feature macro: SEQ_ILLEGAL_TRAP_EN. When it is defined, an illegal
// op sets a sticky flag and the sequencer stops taking new instructions until reset.
//
// state  | meaning
// IDLE   | waiting; pops the queue head when the queue is not empty
// DECODE | load strobes (a_ld/b_ld) and operand fields presented
// EXEC   | exec_en presented for legal ops; illegal ops behave as NOP

module risc_seq_ctrl #(
   parameter int DEPTH = 16,
   parameter int IW    = 14
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [IW-1:0]          instr_in,
   input  logic                   instr_valid,
   output logic                   instr_ready,
   output logic [$clog2(DEPTH):0] q_count,
   output logic                   a_ld,
   output logic                   b_ld,
   output logic                   src_mem,
   output logic [7:0]             imm,
   output logic [3:0]             rd_addr_a,
   output logic [3:0]             rd_addr_b,
   output logic                   exec_en,
   output logic [3:0]             op_sel,
   output logic                   busy,
   output logic                   illegal
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DECODE = 2'd1,
      ST_EXEC   = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [IW-1:0]   instr_q, instr_d;
   logic            a_ld_q, a_ld_d;
   logic            b_ld_q, b_ld_d;
   logic            src_mem_q, src_mem_d;
   logic            exec_en_q, exec_en_d;
   logic            busy_q, busy_d;
   logic            illegal_q, illegal_d;
   logic [IW-1:0]   mem_q [DEPTH];

   logic            push;
   logic            pop;
   logic            halt;
   logic [IW-1:0]   head;

   function automatic logic op_legal(input logic [3:0] op);
      logic ok;
      case (op)
         4'b0000, 4'b0001, 4'b0010, 4'b0100,
         4'b0110, 4'b1100, 4'b1101: ok = 1'b1;
         default:                   ok = 1'b0;
      endcase
      return ok;
   endfunction

`ifdef SEQ_ILLEGAL_TRAP_EN
   assign halt = illegal_q;
`else
   assign halt = 1'b0;
`endif

   // A full queue refuses a push even when it pops in the same cycle.
   assign push = instr_valid && (count_q != FULL_CNT);
   assign pop  = (state_q == ST_IDLE) && (count_q != '0) && !halt;
   assign head = mem_q[rd_ptr_q];

   // Compute the next state of the queue and the sequencer.
   always_comb begin
      state_d   = state_q;
      instr_d   = instr_q;
      a_ld_d    = 1'b0;
      b_ld_d    = 1'b0;
      exec_en_d = 1'b0;
      src_mem_d = src_mem_q;
      busy_d    = busy_q;
      illegal_d = illegal_q;

      wr_ptr_d  = wr_ptr_q + AW'(push);
      rd_ptr_d  = rd_ptr_q + AW'(pop);
      count_d   = count_q + CW'(push) - CW'(pop);

      case (state_q)
         ST_IDLE: begin
            if (pop) begin
               state_d   = ST_DECODE;
               busy_d    = 1'b1;
               instr_d   = head;
               src_mem_d = 1'b0;
               case (head[13:12])
                  2'b00: begin
                     if (head[11:8] == 4'b1110) a_ld_d = 1'b1;
                     else                       b_ld_d = 1'b1;
                  end
                  2'b01: b_ld_d = 1'b1;
                  2'b11: begin
                     a_ld_d    = 1'b1;
                     b_ld_d    = 1'b1;
                     src_mem_d = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         ST_DECODE: begin
            state_d   = ST_EXEC;
            exec_en_d = op_legal(instr_q[11:8]);
         end
         ST_EXEC: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
`ifdef SEQ_ILLEGAL_TRAP_EN
            if (!op_legal(instr_q[11:8])) illegal_d = 1'b1;
`endif
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Register the control state and outputs. Reset discards any queued or in-flight work.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         instr_q   <= '0;
         a_ld_q    <= 1'b0;
         b_ld_q    <= 1'b0;
         src_mem_q <= 1'b0;
         exec_en_q <= 1'b0;
         busy_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         instr_q   <= instr_d;
         a_ld_q    <= a_ld_d;
         b_ld_q    <= b_ld_d;
         src_mem_q <= src_mem_d;
         exec_en_q <= exec_en_d;
         busy_q    <= busy_d;
         illegal_q <= illegal_d;
      end
   end

   // Queue storage is not reset; resetting the pointers empties the queue.
   always_ff @(posedge clk) begin
      if (push && !rst) mem_q[wr_ptr_q] <= instr_in;
   end

   assign instr_ready = (count_q != FULL_CNT);
   assign q_count     = count_q;
   assign a_ld        = a_ld_q;
   assign b_ld        = b_ld_q;
   assign src_mem     = src_mem_q;
   assign exec_en     = exec_en_q;
   assign busy        = busy_q;
   assign imm         = instr_q[7:0];
   assign rd_addr_a   = instr_q[7:4];
   assign rd_addr_b   = instr_q[3:0];
   assign op_sel      = instr_q[11:8];
`ifdef SEQ_ILLEGAL_TRAP_EN
   assign illegal     = illegal_q;
`else
   assign illegal     = 1'b0;
`endif

endmodule

// File: tb/tb_risc_seq_ctrl.sv
// Testbench for risc_seq_ctrl. The stimulus side runs a queue-level reference model
// and queues the expected decode and execute response for each accepted word.
// A monitor process checks the outputs on every falling clock edge.
`timescale 1ns/1ps

module tb_risc_seq_ctrl;

   localparam int DEPTH = 16;
   localparam int IW    = 14;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [IW-1:0] instr_in = '0;
   logic          instr_valid = 1'b0;
   logic          instr_ready;
   logic [4:0]    q_count;
   logic          a_ld, b_ld, src_mem, exec_en, busy, illegal;
   logic [7:0]    imm;
   logic [3:0]    rd_addr_a, rd_addr_b, op_sel;

   risc_seq_ctrl #(.DEPTH(DEPTH), .IW(IW)) dut (
      .clk(clk), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .q_count(q_count), .a_ld(a_ld), .b_ld(b_ld),
      .src_mem(src_mem), .imm(imm), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .exec_en(exec_en), .op_sel(op_sel), .busy(busy), .illegal(illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       a, b, src, ex, cls11;
      logic [7:0] imm;
      logic [3:0] ra, rb, op;
   } exp_t;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   logic [IW-1:0] mq[$];
   exp_t          expq[$];
   int            m_phase = 0;   // 0 idle, 1 decode, 2 exec
   bit            m_halted = 0;
   bit            m_illegal = 0;
   bit            m_cur_ex = 0;
   bit            started = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   function automatic exp_t mk_exp(input logic [IW-1:0] w);
      exp_t e;
      logic [1:0] c;
      logic [3:0] o;
      c = w[13:12];
      o = w[11:8];
      e.a     = (c == 2'b11) || (c == 2'b00 && o == 4'hE);
      e.b     = (c == 2'b11) || (c == 2'b01) || (c == 2'b00 && o != 4'hE);
      e.src   = (c == 2'b11);
      e.cls11 = (c == 2'b11);
      e.imm   = w[7:0];
      e.ra    = w[7:4];
      e.rb    = w[3:0];
      e.op    = o;
      e.ex    = o inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h6, 4'hC, 4'hD};
      return e;
   endfunction

   // One clock of stimulus: drive the inputs, step the model at the rising edge, then move past the next falling edge.
   task automatic step(input logic v, input logic [IW-1:0] w, input logic r);
      bit acc;
      exp_t e;
      instr_valid = v;
      instr_in    = w;
      rst         = r;
      @(posedge clk);
      if (r) begin
         mq.delete();
         expq.delete();
         m_phase   = 0;
         m_halted  = 0;
         m_illegal = 0;
         started   = 1;
      end else begin
         acc = v && (mq.size() < DEPTH);
         if (m_phase == 2) begin
`ifdef SEQ_ILLEGAL_TRAP_EN
            if (!m_cur_ex) begin
               m_halted  = 1;
               m_illegal = 1;
            end
`endif
            m_phase = 0;
         end else if (m_phase == 1) begin
            m_phase = 2;
         end else if (mq.size() > 0 && !m_halted) begin
            e = mk_exp(mq.pop_front());
            m_cur_ex = e.ex;
            m_phase  = 1;
         end
         if (acc) begin
            mq.push_back(w);
            expq.push_back(mk_exp(w));
         end
      end
      @(negedge clk);
      #1;
   endtask

   // Monitor: on each falling edge, compare the DUT outputs with the model and the expected-response queue.
   initial begin
      int   mon_ph;
      bit   prev_busy;
      exp_t cur;
      mon_ph = 0;
      prev_busy = 0;
      forever begin
         @(negedge clk);
         if (started) begin
            chk("q_count", 32'(q_count), 32'(mq.size()));
            chk("instr_ready", 32'(instr_ready), 32'(mq.size() != DEPTH));
            chk("busy", 32'(busy), 32'(m_phase != 0));
            chk("illegal", 32'(illegal), 32'(m_illegal));
            if (rst) begin
               mon_ph = 0;
               chk("strobes_after_rst", 32'({a_ld, b_ld, exec_en}), 32'd0);
            end else if (busy && !prev_busy) begin
               if (expq.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_issue: got busy=1 expected no queued instruction at %0t", $time);
               end else begin
                  cur = expq.pop_front();
                  chk("dec_a_ld", 32'(a_ld), 32'(cur.a));
                  chk("dec_b_ld", 32'(b_ld), 32'(cur.b));
                  chk("dec_src_mem", 32'(src_mem), 32'(cur.src));
                  chk("dec_imm", 32'(imm), 32'(cur.imm));
                  chk("dec_op_sel", 32'(op_sel), 32'(cur.op));
                  chk("dec_exec_en", 32'(exec_en), 32'd0);
                  if (cur.cls11) begin
                     chk("dec_rd_addr_a", 32'(rd_addr_a), 32'(cur.ra));
                     chk("dec_rd_addr_b", 32'(rd_addr_b), 32'(cur.rb));
                  end
                  mon_ph = 1;
               end
            end else if (mon_ph == 1) begin
               chk("exe_exec_en", 32'(exec_en), 32'(cur.ex));
               chk("exe_op_sel", 32'(op_sel), 32'(cur.op));
               chk("exe_imm", 32'(imm), 32'(cur.imm));
               chk("exe_loads", 32'({a_ld, b_ld}), 32'd0);
               mon_ph = 0;
            end else begin
               chk("idle_strobes", 32'({a_ld, b_ld, exec_en}), 32'd0);
            end
            prev_busy = busy;
         end
      end
   end

   // Stimulus: directed scenarios first, then randomized traffic with occasional resets.
   initial begin
      step(0, '0, 1);
      step(1, 14'h3FFF, 1);
      chk("rst_imm", 32'(imm), 32'd0);
      chk("rst_op_sel", 32'(op_sel), 32'd0);
      chk("rst_rd_addr", 32'({rd_addr_a, rd_addr_b}), 32'd0);
      chk("rst_src_mem", 32'(src_mem), 32'd0);
      chk("rst_instr_ready", 32'(instr_ready), 32'd1);
      chk("rst_q_count", 32'(q_count), 32'd0);

      // class 00 op 1110: A load from imm, then execute as NOP
      step(1, 14'b00_1110_00000101, 0);
      repeat (6) step(0, '0, 0);
      // class 11 op 0100: both loads from memory, then execute
      step(1, 14'b11_0100_0011_1100, 0);
      repeat (6) step(0, '0, 0);

      // Push back-to-back until the queue is full, then drain it in order.
      for (int i = 0; i < 36; i++) step(1, 14'($urandom_range(0, 16383)), 0);
      repeat (60) step(0, '0, 0);

      // Reset during EXEC of op 0110 while more words are still queued.
      step(1, 14'b01_0110_00000001, 0);
      step(1, 14'($urandom_range(0, 16383)), 0);
      step(1, 14'($urandom_range(0, 16383)), 0);
      step(1, 14'($urandom_range(0, 16383)), 0);
      for (int i = 0; i < 10 && m_phase != 2; i++) step(0, '0, 0);
      chk("reached_exec", 32'(m_phase), 32'd2);
      step(1, 14'h0100, 1);
      step(0, '0, 0);
      chk("post_abort_q_count", 32'(q_count), 32'd0);
      chk("post_abort_busy", 32'(busy), 32'd0);
      repeat (4) step(0, '0, 0);

`ifdef SEQ_ILLEGAL_TRAP_EN
      step(1, 14'b00_1111_00000000, 0);
      step(1, 14'b11_0000_00010010, 0);
      repeat (12) step(0, '0, 0);
      chk("trap_illegal", 32'(illegal), 32'd1);
      chk("trap_q_count", 32'(q_count), 32'd1);
      step(0, '0, 1);
      step(0, '0, 0);
`endif

      for (int i = 0; i < 1500; i++) begin
         logic v;
         logic r;
         if (i < 750) v = ($urandom_range(0, 3) == 0);
         else         v = ($urandom_range(0, 3) != 0);
         r = ($urandom_range(0, 249) == 0);
         step(v, 14'($urandom_range(0, 16383)), r);
      end
      repeat (60) step(0, '0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
